// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing front end.
// Holds the SNG controller state encoding and the LFSR lock-up constant.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } sng_state_e;

    // All-ones word: the state an XNOR LFSR can never leave.
    function automatic logic [31:0] lfsr_lockup(input int unsigned num_bits);
        logic [63:0] ones;
        ones = (64'd1 << num_bits) - 64'd1;
        return ones[31:0];
    endfunction

endpackage

// File: rtl/sng_len_counter.sv
// Stream length counter for the SNG controller: latches the length on start,
// counts accepted bits and flags the last one; hold/clear gate the step.
module sng_len_counter #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [NUM_BITS-1:0] i_len,
    input  logic                i_run,
    input  logic                i_hold,
    input  logic                i_clear,
    output logic                o_step,
    output logic                o_last
);

    logic [NUM_BITS-1:0] len_q;
    logic [NUM_BITS-1:0] cnt_q;
    logic [NUM_BITS-1:0] last_idx;

    // len 0 means a full LFSR period of 2^N-1 bits, so the last index is 2^N-2.
    always_comb begin
        last_idx = len_q - NUM_BITS'(1);
        if (len_q == '0) begin
            last_idx = ~NUM_BITS'(1);
        end
    end

    // An aborting cycle neither emits nor counts a bit.
    assign o_step = i_run & ~i_hold & ~i_clear;
    assign o_last = o_step & (cnt_q == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
        end else if (i_load) begin
            len_q <= i_len;
            cnt_q <= '0;
        end else if (o_step) begin
            cnt_q <= cnt_q + NUM_BITS'(1);
        end
    end

endmodule

// File: rtl/uni_sng_ctrl.sv
// Unipolar stochastic number generator controller: seeds an external LFSR,
// compares each random word against a latched value and counts emitted ones.
module uni_sng_ctrl
    import sc_pkg::*;
#(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [NUM_BITS-1:0] i_value,
    input  logic [NUM_BITS-1:0] i_seed,
    input  logic [NUM_BITS-1:0] i_len,
    input  logic                i_hold,
    input  logic                i_clear,
    input  logic [NUM_BITS-1:0] i_rand,
    output logic                o_lfsr_en,
    output logic                o_seed_dv,
    output logic [NUM_BITS-1:0] o_seed,
    output logic                o_bit,
    output logic                o_bit_vld,
    output logic                o_busy,
    output logic                o_done,
    output logic [NUM_BITS-1:0] o_ones
);

    localparam logic [NUM_BITS-1:0] LOCKUP = NUM_BITS'(lfsr_lockup(NUM_BITS));

    sng_state_e          state;
    sng_state_e          state_n;
    logic [NUM_BITS-1:0] value_q;
    logic [NUM_BITS-1:0] seed_q;
    logic [NUM_BITS-1:0] ones_q;
    logic                start_acc;
    logic                run_st;
    logic                step;
    logic                last;
    logic                bit_raw;

    assign start_acc = (state == IDLE) & i_start & ~i_clear;
    assign run_st    = (state == RUN);
    assign bit_raw   = (i_rand < value_q);

    sng_len_counter #(
        .NUM_BITS (NUM_BITS)
    ) u_len (
        .clk     (clk),
        .rst     (rst),
        .i_load  (start_acc),
        .i_len   (i_len),
        .i_run   (run_st),
        .i_hold  (i_hold),
        .i_clear (i_clear),
        .o_step  (step),
        .o_last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (i_clear) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_start) state_n = SEED;
                SEED:    state_n = RUN;
                RUN:     if (last) state_n = DONE;
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Lock-up seed is swapped for zero so the LFSR always walks its full cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            seed_q  <= '0;
            ones_q  <= '0;
        end else if (start_acc) begin
            value_q <= i_value;
            seed_q  <= (i_seed == LOCKUP) ? '0 : i_seed;
            ones_q  <= '0;
        end else if (step) begin
            ones_q  <= ones_q + NUM_BITS'(bit_raw);
        end
    end

    always_comb begin
        o_lfsr_en = (state == SEED) | step;
        o_seed_dv = (state == SEED);
        o_seed    = (state == SEED) ? seed_q : '0;
        o_bit_vld = step;
        o_bit     = step & bit_raw;
        o_busy    = (state != IDLE);
        o_done    = (state == DONE);
    end

    assign o_ones = ones_q;

endmodule

// File: tb/tb_uni_sng_ctrl.sv
// Scoreboard bench for uni_sng_ctrl driving an 8-bit XNOR LFSR model.
// Stimulus queues expected bits, done records and output probes; the monitor checks them.
module tb_uni_sng_ctrl;

    localparam int NB = 8;

    localparam logic [31:0] M_EN   = 32'h0020_0000;
    localparam logic [31:0] M_DV   = 32'h0010_0000;
    localparam logic [31:0] M_SEED = 32'h000F_F000;
    localparam logic [31:0] M_BIT  = 32'h0000_0800;
    localparam logic [31:0] M_VLD  = 32'h0000_0400;
    localparam logic [31:0] M_BUSY = 32'h0000_0200;
    localparam logic [31:0] M_DONE = 32'h0000_0100;
    localparam logic [31:0] M_ONES = 32'h0000_00FF;
    localparam logic [31:0] M_ALL  = 32'h003F_FFFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [NB-1:0] i_value = '0;
    logic [NB-1:0] i_seed = '0;
    logic [NB-1:0] i_len = '0;
    logic          i_hold = 1'b0;
    logic          i_clear = 1'b0;
    logic [NB-1:0] i_rand;
    logic          o_lfsr_en, o_seed_dv, o_bit, o_bit_vld, o_busy, o_done;
    logic [NB-1:0] o_seed, o_ones;

    uni_sng_ctrl #(.NUM_BITS(NB)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_value(i_value), .i_seed(i_seed),
        .i_len(i_len), .i_hold(i_hold), .i_clear(i_clear), .i_rand(i_rand),
        .o_lfsr_en(o_lfsr_en), .o_seed_dv(o_seed_dv), .o_seed(o_seed), .o_bit(o_bit),
        .o_bit_vld(o_bit_vld), .o_busy(o_busy), .o_done(o_done), .o_ones(o_ones)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External maximal-length XNOR LFSR, taps 8,6,5,4.
    logic [NB-1:0] lfsr = '0;
    always @(posedge clk) begin
        if (o_seed_dv)      lfsr <= o_seed;
        else if (o_lfsr_en) lfsr <= {lfsr[6:0], ~(lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3])};
    end
    assign i_rand = lfsr;

    logic [31:0] outs;
    assign outs = {10'd0, o_lfsr_en, o_seed_dv, o_seed, o_bit, o_bit_vld, o_busy, o_done, o_ones};

    typedef struct {
        int          cyc;
        logic [31:0] mask;
        logic [31:0] exp;
        string       name;
    } probe_t;

    typedef struct {
        int cyc;
        int ones;
        int nbits;
    } done_t;

    probe_t probe_q[$];
    done_t  done_q[$];
    bit     bit_q[$];

    int checks = 0;
    int errors = 0;
    int nbits  = 0;
    probe_t pr;
    done_t  dr;
    bit     eb;

    always @(negedge clk) begin
        while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
            pr = probe_q.pop_front();
            checks++;
            if (pr.cyc < cyc) begin
                errors++;
                $display("FAIL %s probe missed at cycle %0d", pr.name, cyc);
            end else if ((outs & pr.mask) !== (pr.exp & pr.mask)) begin
                errors++;
                $display("FAIL %s cycle %0d got %06h want %06h", pr.name, cyc,
                         outs & pr.mask, pr.exp & pr.mask);
            end
        end
        if (o_seed_dv) nbits = 0;
        if (o_bit_vld) begin
            nbits++;
            if (bit_q.size() > 0) begin
                eb = bit_q.pop_front();
                checks++;
                if (o_bit !== eb) begin
                    errors++;
                    $display("FAIL bit cycle %0d got %b want %b", cyc, o_bit, eb);
                end
            end
        end
        if (o_done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cycle %0d got 1 want 0", cyc);
            end else begin
                dr = done_q.pop_front();
                if (cyc != dr.cyc) begin
                    errors++;
                    $display("FAIL done_cycle got %0d want %0d", cyc, dr.cyc);
                end
                checks++;
                if (int'(o_ones) != dr.ones) begin
                    errors++;
                    $display("FAIL ones got %0d want %0d", o_ones, dr.ones);
                end
                checks++;
                if (nbits != dr.nbits) begin
                    errors++;
                    $display("FAIL nbits got %0d want %0d", nbits, dr.nbits);
                end
            end
        end else if (done_q.size() > 0 && cyc > done_q[0].cyc) begin
            dr = done_q.pop_front();
            checks++;
            errors++;
            $display("FAIL done_timeout got none want cycle %0d", dr.cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int c, input logic [31:0] m, input logic [31:0] e, input string n);
        probe_q.push_back('{c, m, e, n});
    endtask

    task automatic push_bits(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) bit_q.push_back(pat[i]);
    endtask

    task automatic push_const(input bit b, input int n);
        for (int i = 0; i < n; i++) bit_q.push_back(b);
    endtask

    task automatic start(input logic [7:0] v, input logic [7:0] s, input logic [7:0] l, output int sc);
        i_value = v;
        i_seed  = s;
        i_len   = l;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        sc = cyc;
    endtask

    task automatic run(input logic [7:0] v, input logic [7:0] s, input logic [7:0] l,
                       input logic [7:0] es, input int ones, input string n);
        int sc;
        int le;
        le = (l == 8'd0) ? 255 : int'(l);
        start(v, s, l, sc);
        probe(sc, M_EN | M_DV | M_SEED | M_VLD | M_BUSY | M_DONE | M_ONES,
              M_EN | M_DV | ({24'd0, es} << 12) | M_BUSY, {n, "_seed"});
        done_q.push_back('{sc + 1 + le, ones, le});
        repeat (le + 2) tick();
        probe(cyc, M_BUSY | M_DONE | M_ONES, ones, {n, "_hold_ones"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        probe(1, M_ALL, 32'd0, "reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        probe(cyc, M_ALL, 32'd0, "idle_after_reset");
        tick();

        // clear wins over start in IDLE
        i_start = 1'b1;
        i_clear = 1'b1;
        tick();
        i_start = 1'b0;
        i_clear = 1'b0;
        probe(cyc, M_BUSY | M_EN | M_DV, 32'd0, "clear_beats_start");
        tick();

        // words 01,03,07,0F,1E,3D,7A from seed 01
        push_bits(32'b01111, 5);
        run(8'h10, 8'h01, 8'd5, 8'h01, 4, "short_v10");
        push_bits(32'b011, 3);
        run(8'h07, 8'h01, 8'd3, 8'h01, 2, "equal_word");
        push_bits(32'b0000011, 7);
        run(8'h04, 8'h01, 8'd7, 8'h01, 2, "short_v04");

        run(8'd128, 8'h01, 8'd0, 8'h01, 128, "full_128");
        push_const(1'b0, 255);
        run(8'd0, 8'h5A, 8'd0, 8'h5A, 0, "full_0");
        push_const(1'b1, 255);
        run(8'd255, 8'h81, 8'd0, 8'h81, 255, "full_255");
        run(8'd100, 8'hFF, 8'd0, 8'h00, 100, "lockup_seed");

        // hold for 5 cycles after 3 bits of a 10-bit stream
        start(8'hFF, 8'h5A, 8'd10, sc);
        probe(sc, M_EN | M_DV | M_SEED | M_BUSY, M_EN | M_DV | (32'h5A << 12) | M_BUSY, "hold_seed");
        done_q.push_back('{sc + 16, 10, 10});
        repeat (4) tick();
        i_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            probe(cyc, M_EN | M_VLD | M_BUSY, M_BUSY, "hold_stall");
            tick();
        end
        i_hold = 1'b0;
        probe(cyc, M_EN | M_VLD, M_EN | M_VLD, "hold_release");
        repeat (9) tick();

        // abort at bit index 4, then a one-bit stream
        start(8'hFF, 8'h33, 8'd20, sc);
        repeat (5) tick();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        probe(cyc, M_BUSY | M_DONE | M_VLD | M_ONES, 32'd4, "clear_abort");
        start(8'hFF, 8'h10, 8'd1, sc);
        probe(sc, M_SEED | M_ONES | M_BUSY, (32'h10 << 12) | M_BUSY, "len1_seed");
        done_q.push_back('{sc + 2, 1, 1});
        repeat (4) tick();

        // start pulses while busy are ignored
        start(8'hFF, 8'h02, 8'd3, sc);
        done_q.push_back('{sc + 4, 3, 3});
        repeat (2) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        probe(cyc, M_BUSY | M_ONES, 32'd3, "start_ignored");
        repeat (3) tick();

        // asynchronous reset between edges in RUN
        start(8'hFF, 8'h77, 8'd0, sc);
        repeat (10) tick();
        #1;
        rst = 1'b1;
        probe(cyc, M_ALL, 32'd0, "async_reset");
        tick();
        probe(cyc, M_ALL, 32'd0, "reset_held");
        rst = 1'b0;
        tick();
        probe(cyc, M_ALL, 32'd0, "reset_released");
        tick();
        push_bits(32'b011, 3);
        run(8'h07, 8'h01, 8'd3, 8'h01, 2, "after_reset");

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
